bhand_age_sink: RTL

//  Terminating stage for a chain of cycle-counting buffered-handshake stages: consumes the (data, age) stream.

---
 rtl/bhand_age_sink_pkg.sv | 11 +
 rtl/bhand_age_sink_sat_counter.sv | 23 ++
 rtl/bhand_age_sink.sv | 104 ++++++++++
 3 files changed

// File: rtl/bhand_age_sink_pkg.sv
// rtl/bhand_age_sink_pkg.sv - shared FSM encodings and default widths for the buffered-handshake age sink
package bhand_age_sink_pkg;

  localparam logic [0:0] BH_EMPTY = 1'b0;
  localparam logic [0:0] BH_FULL  = 1'b1;

  localparam int BH_DATA_WIDTH  = 8;
  localparam int BH_COUNT_WIDTH = 4;
  localparam int BH_STAT_WIDTH  = 16;

endpackage

// File: rtl/bhand_age_sink_sat_counter.sv
// rtl/bhand_age_sink_sat_counter.sv - saturating event counter with synchronous clear
module bhand_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // clr beats a same-cycle increment, so the clearing event is never counted
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/bhand_age_sink.sv
// rtl/bhand_age_sink.sv - terminating age-counting handshake stage with stale flag and latency stats
// Optional macro AGE_DROP_EN: consume stale inputs without loading them and count them in drop_cnt.
module bhand_age_sink
  import bhand_age_sink_pkg::*;
#(
  parameter int DATA_WIDTH  = BH_DATA_WIDTH,
  parameter int COUNT_WIDTH = BH_COUNT_WIDTH,
  parameter int STAT_WIDTH  = BH_STAT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  idata,
  input  logic                   idata_vld,
  output logic                   idata_rdy,
  input  logic [COUNT_WIDTH-1:0] icount,
  input  logic                   cnt_en,
  input  logic [COUNT_WIDTH-1:0] threshold,
  output logic [DATA_WIDTH-1:0]  odata,
  output logic                   odata_vld,
  input  logic                   odata_rdy,
  output logic [COUNT_WIDTH-1:0] ocount,
  output logic                   ostale,
  input  logic                   stats_clr,
  output logic [COUNT_WIDTH-1:0] max_age,
  output logic [STAT_WIDTH-1:0]  xfer_cnt,
  output logic [STAT_WIDTH-1:0]  drop_cnt
);

  logic [0:0]             state_q;
  logic                   shift_in;
  logic                   shift_out;
  logic                   drop;
  logic                   load;
  logic [COUNT_WIDTH:0]   in_sum;
  logic [COUNT_WIDTH:0]   hold_sum;
  logic [COUNT_WIDTH-1:0] in_age;
  logic [COUNT_WIDTH-1:0] hold_age;

  assign odata_vld = (state_q == BH_FULL);
  assign idata_rdy = !odata_vld || odata_rdy;
  assign shift_in  = idata_vld && idata_rdy;
  assign shift_out = odata_vld && odata_rdy;

  // Ages clamp instead of wrapping so a long-held item cannot drop back below threshold
  assign in_sum   = {1'b0, icount} + {{COUNT_WIDTH{1'b0}}, cnt_en};
  assign hold_sum = {1'b0, ocount} + {{COUNT_WIDTH{1'b0}}, cnt_en};
  assign in_age   = in_sum[COUNT_WIDTH]   ? '1 : in_sum[COUNT_WIDTH-1:0];
  assign hold_age = hold_sum[COUNT_WIDTH] ? '1 : hold_sum[COUNT_WIDTH-1:0];

`ifdef AGE_DROP_EN
  assign drop = shift_in && (threshold != '0) && (in_age >= threshold);
`else
  assign drop = 1'b0;
`endif

  assign load   = shift_in && !drop;
  assign ostale = odata_vld && (threshold != '0) && (ocount >= threshold);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BH_EMPTY;
      odata   <= '0;
      ocount  <= '0;
    end else begin
      if (load) begin
        state_q <= BH_FULL;
        odata   <= idata;
        ocount  <= in_age;
      end else begin
        if (shift_out) begin
          state_q <= BH_EMPTY;
        end
        if (odata_vld) begin
          ocount <= hold_age;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      max_age <= '0;
    end else if (shift_out && (ocount > max_age)) begin
      max_age <= ocount;
    end
  end

  bhand_sat_counter #(.WIDTH(STAT_WIDTH)) u_xfer_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (stats_clr),
    .inc   (shift_out),
    .count (xfer_cnt)
  );

  bhand_sat_counter #(.WIDTH(STAT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (stats_clr),
    .inc   (drop),
    .count (drop_cnt)
  );

endmodule
